// File: rtl/tick_countdown_pkg.sv
// tick_countdown_pkg: state type, BCD digit width and digit-validity helper
// shared by the countdown timer and its sub-blocks.
package tick_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_DONE
    } state_t;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    function automatic logic bcdDigitValid(input logic [BCD_W-1:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// tick_sync_edge: multi-flop synchroniser for an asynchronous square wave plus
// a toggle detector that emits a one-cycle step on every edge of the input.
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_step
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Both rising and falling edges of the synchronised wave count as a step.
    assign o_step = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/tick_countdown.sv
// tick_countdown: BCD mm:ss countdown timer stepped by each edge of the divider wave.
// Optional: define TICK_COUNTDOWN_AUTO_RELOAD_EN to reload the last valid load on expiry and keep running.
module tick_countdown
    import tick_countdown_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    logic       w_step;
    state_t     r_state, w_stateNext;
    logic [7:0] r_min, r_sec, w_minNext, w_secNext;
    logic [7:0] w_decMin, w_decSec;
    logic [7:0] w_loadMinVal;
    logic       w_loadValid;
    logic       w_done, w_loadErr;
    logic       r_running, r_done, r_expired, r_loadErr;

    tick_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_syncEdge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(tick_in),
        .o_step (w_step)
    );

    assign w_loadMinVal = {4'd0, load_min[7:4]} * 8'd10 + {4'd0, load_min[3:0]};
    assign w_loadValid  = bcdDigitValid(load_min[7:4]) && bcdDigitValid(load_min[3:0])
                       && bcdDigitValid(load_sec[3:0]) && (load_sec[7:4] <= SEC_TENS_MAX)
                       && (w_loadMinVal <= 8'(MAX_MIN));

    // One-second BCD decrement with borrow through sec tens into minutes; holds at 00:00.
    always_comb begin
        w_decMin = r_min;
        w_decSec = r_sec;
        if (r_sec[3:0] != 4'd0) begin
            w_decSec[3:0] = r_sec[3:0] - 4'd1;
        end else if (r_sec[7:4] != 4'd0) begin
            w_decSec = {r_sec[7:4] - 4'd1, 4'd9};
        end else if (r_min != 8'h00) begin
            w_decSec = 8'h59;
            if (r_min[3:0] != 4'd0) begin
                w_decMin[3:0] = r_min[3:0] - 4'd1;
            end else begin
                w_decMin = {r_min[7:4] - 4'd1, 4'd9};
            end
        end
    end

`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
    logic [7:0] r_reloadMin, r_reloadSec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reloadMin <= 8'h00;
            r_reloadSec <= 8'h00;
        end else if (!clear && load && (r_state != ST_RUN) && w_loadValid) begin
            r_reloadMin <= load_min;
            r_reloadSec <= load_sec;
        end
    end
`endif

    // Command chain: clear beats load beats pause beats start; a step only counts when nothing else acts.
    always_comb begin
        w_stateNext = r_state;
        w_minNext   = r_min;
        w_secNext   = r_sec;
        w_done      = 1'b0;
        w_loadErr   = 1'b0;
        if (clear) begin
            w_stateNext = ST_IDLE;
            w_minNext   = 8'h00;
            w_secNext   = 8'h00;
        end else if (load && (r_state != ST_RUN)) begin
            if (w_loadValid) begin
                w_stateNext = ST_IDLE;
                w_minNext   = load_min;
                w_secNext   = load_sec;
            end else begin
                w_loadErr = 1'b1;
            end
        end else if (pause && (r_state == ST_RUN)) begin
            w_stateNext = ST_PAUSED;
        end else if (start && ((r_state == ST_IDLE) || (r_state == ST_PAUSED))
                     && ({r_min, r_sec} != 16'h0000)) begin
            w_stateNext = ST_RUN;
        end else if (w_step && (r_state == ST_RUN)) begin
            w_minNext = w_decMin;
            w_secNext = w_decSec;
            if ({w_decMin, w_decSec} == 16'h0000) begin
                w_done = 1'b1;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
                w_minNext = r_reloadMin;
                w_secNext = r_reloadSec;
`else
                w_stateNext = ST_DONE;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_min     <= 8'h00;
            r_sec     <= 8'h00;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
            r_loadErr <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_min     <= w_minNext;
            r_sec     <= w_secNext;
            r_running <= (w_stateNext == ST_RUN);
            r_done    <= w_done;
            r_expired <= (w_stateNext == ST_DONE);
            r_loadErr <= w_loadErr;
        end
    end

    assign min_bcd  = r_min;
    assign sec_bcd  = r_sec;
    assign running  = r_running;
    assign done     = r_done;
    assign expired  = r_expired;
    assign load_err = r_loadErr;

endmodule

// File: tb/tb_tick_countdown.sv
// tb_tick_countdown: scoreboard bench for the BCD countdown timer; expected
// results come from a seconds-count model and are queued as each tick is driven.
`timescale 1ns/1ps
module tb_tick_countdown;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_MIN     = 99;

    typedef struct {
        logic [7:0] min;
        logic [7:0] sec;
        logic       done;
        logic       run;
        logic       exp;
    } expect_t;

    expect_t expQ[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_min = 8'h00;
    logic [7:0] load_sec = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, done, expired, load_err;

    int errors = 0;
    int checks = 0;

    int mdlTotal  = 0;
    int mdlReload = 0;
    bit mdlRun    = 1'b0;
    bit mdlExp    = 1'b0;

    tick_countdown #(
        .SYNC_STAGES(SYNC_STAGES),
        .MAX_MIN    (MAX_MIN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_in (tick_in),
        .load    (load),
        .load_min(load_min),
        .load_sec(load_sec),
        .start   (start),
        .pause   (pause),
        .clear   (clear),
        .min_bcd (min_bcd),
        .sec_bcd (sec_bcd),
        .running (running),
        .done    (done),
        .expired (expired),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] toBcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int fromBcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] mdlValue();
        return {toBcd(mdlTotal / 60), toBcd(mdlTotal % 60)};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                                 input logic st, input logic pa, input logic cl);
        @(negedge clk);
        load = ld; load_min = lm; load_sec = ls;
        start = st; pause = pa; clear = cl;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic doLoad(input logic [7:0] lm, input logic [7:0] ls, input string tag);
        bit valid;
        bit errExp;
        valid = (lm[7:4] <= 9) && (lm[3:0] <= 9) && (ls[7:4] <= 5) && (ls[3:0] <= 9)
             && (fromBcd(lm) <= MAX_MIN);
        applyStimulus(1'b1, lm, ls, 1'b0, 1'b0, 1'b0);
        errExp = 1'b0;
        if (!mdlRun) begin
            if (valid) begin
                mdlTotal  = fromBcd(lm) * 60 + fromBcd(ls);
                mdlReload = mdlTotal;
                mdlExp    = 1'b0;
            end else begin
                errExp = 1'b1;
            end
        end
        checkOutput({tag, "_err"}, {15'd0, load_err}, {15'd0, errExp});
        checkOutput({tag, "_val"}, {min_bcd, sec_bcd}, mdlValue());
        @(posedge clk);
        #1;
        checkOutput({tag, "_errpulse"}, {15'd0, load_err}, 16'd0);
    endtask

    task automatic doStart(input string tag);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        if (!mdlRun && !mdlExp && mdlTotal != 0) mdlRun = 1'b1;
        checkOutput({tag, "_run"}, {15'd0, running}, {15'd0, mdlRun});
    endtask

    task automatic doClear(input string tag);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        mdlTotal = 0; mdlRun = 1'b0; mdlExp = 1'b0;
        checkOutput({tag, "_val"}, {min_bcd, sec_bcd}, 16'h0000);
        checkOutput({tag, "_exp"}, {15'd0, expired}, 16'd0);
    endtask

    // One tick_in toggle, optionally with pause/start landing on the resulting step.
    task automatic applyTick(input logic pa, input logic st, input string tag);
        expect_t     e;
        logic [15:0] prev;
        prev   = mdlValue();
        e.done = 1'b0;
        if (pa && mdlRun) begin
            mdlRun = 1'b0;
        end else if (st && !mdlRun && !mdlExp && mdlTotal != 0) begin
            mdlRun = 1'b1;
        end else if (mdlRun) begin
            mdlTotal--;
            if (mdlTotal == 0) begin
                e.done = 1'b1;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
                mdlTotal = mdlReload;
`else
                mdlRun = 1'b0;
                mdlExp = 1'b1;
`endif
            end
        end
        {e.min, e.sec} = mdlValue();
        e.run = mdlRun;
        e.exp = mdlExp;
        expQ.push_back(e);

        @(negedge clk);
        tick_in = ~tick_in;
        repeat (SYNC_STAGES) @(posedge clk);
        #1;
        checkOutput({tag, "_early"}, {min_bcd, sec_bcd}, prev);
        @(negedge clk);
        pause = pa; start = st;
        @(posedge clk);
        #1;
        pause = 1'b0; start = 1'b0;

        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 16'd0, 16'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_val"}, {min_bcd, sec_bcd}, {e.min, e.sec});
            checkOutput({tag, "_done"}, {15'd0, done}, {15'd0, e.done});
            checkOutput({tag, "_run"}, {15'd0, running}, {15'd0, e.run});
            checkOutput({tag, "_exp"}, {15'd0, expired}, {15'd0, e.exp});
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_val", {min_bcd, sec_bcd}, 16'h0000);
        checkOutput("rst_flags", {12'd0, running, done, expired, load_err}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] 01:00 countdown and latency");
        doLoad(8'h01, 8'h00, "ld0100");
        doStart("st0100");
        applyTick(1'b0, 1'b0, "t0059");
        for (int i = 0; i < 3; i++) applyTick(1'b0, 1'b0, "t0056");

        $display("[TB] expiry from 00:02");
        doClear("clr1");
        doLoad(8'h00, 8'h02, "ld0002");
        doStart("st0002");
        applyTick(1'b0, 1'b0, "t0001");
        applyTick(1'b0, 1'b0, "t0000");
        @(posedge clk);
        #1;
        checkOutput("done_once", {15'd0, done}, 16'd0);
        checkOutput("exp_hold", {15'd0, expired}, {15'd0, mdlExp});
        applyTick(1'b0, 1'b0, "t_after");
        doStart("st_ignored");
        doClear("clr2");

        $display("[TB] load validation");
        doLoad(8'h00, 8'h60, "ld_sec60");
        doLoad(8'hA0, 8'h00, "ld_minA0");
        doLoad(8'h00, 8'h0A, "ld_secA");
        doLoad(8'h99, 8'h59, "ld9959");
        doStart("st9959");
        applyTick(1'b0, 1'b0, "t9958");

        $display("[TB] pause/start coincident with step");
        doClear("clr3");
        doLoad(8'h00, 8'h10, "ld0010");
        doStart("st0010");
        applyTick(1'b1, 1'b0, "t_pause");
        applyTick(1'b0, 1'b0, "t_paused");
        applyTick(1'b0, 1'b1, "t_start");
        applyTick(1'b0, 1'b0, "t0009");
        doLoad(8'h00, 8'h05, "ld_inrun");

        $display("[TB] asynchronous reset mid-count");
        doClear("clr4");
        doLoad(8'h00, 8'h30, "ld0030");
        doStart("st0030");
        applyTick(1'b0, 1'b0, "t0029");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_val", {min_bcd, sec_bcd}, 16'h0000);
        checkOutput("arst_flags", {12'd0, running, done, expired, load_err}, 16'd0);
        mdlTotal = 0; mdlRun = 1'b0; mdlExp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyTick(1'b0, 1'b0, "t_postrst1");
        applyTick(1'b0, 1'b0, "t_postrst2");

`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
        $display("[TB] auto reload");
        doLoad(8'h00, 8'h02, "ld_ar");
        doStart("st_ar");
        for (int i = 0; i < 4; i++) applyTick(1'b0, 1'b0, "t_ar");
        checkOutput("ar_final", {min_bcd, sec_bcd}, 16'h0002);
        checkOutput("ar_running", {15'd0, running}, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_countdown.md
Name: tick_countdown

Overview:
- Consumes the slow square wave from the clock divider and runs a BCD mm:ss countdown timer in the fast clk domain.
- Stage chain:
  - tick_in is synchronised.
  - Every transition of tick_in (both edges) is one timer step, i.e. one second at default divider settings.
  - BCD minutes/seconds feed the display stage.
- FSM provides load/start/pause/clear control and an expiry indication.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on tick_in (min 2).
- MAX_MIN, 99, largest accepted minutes load value (BCD-valid, ≤99).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick_in  in  1  divider output square wave, asynchronous to clk
- load  in  1  load request, single-cycle pulse
- load_min  in  8  BCD minutes {tens, ones}
- load_sec  in  8  BCD seconds {tens, ones}
- start  in  1  start/resume pulse
- pause  in  1  pause pulse
- clear  in  1  clear pulse
- min_bcd  out  8  current minutes, BCD
- sec_bcd  out  8  current seconds, BCD
- running  out  1  high in RUN
- done  out  1  one-cycle pulse on expiry
- expired  out  1  level, high in DONE
- load_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset (async, rst_n low):
  - All synchroniser flops 0 and edge-detect history 0.
  - min_bcd = sec_bcd = 8'h00; state IDLE.
  - running, done, expired and load_err all 0.
- Step generation:
  - step = 1 for one cycle when the synchroniser output differs from its registered previous value.
  - Latency: a tick_in transition shows on sec_bcd after SYNC_STAGES+1 clk edges.
- FSM states: IDLE, RUN, PAUSED, DONE.
- Command priority: clear > load > pause > start.
- clear: from any state, value becomes 00:00, state IDLE, expired 0.
- load (in IDLE, PAUSED or DONE):
  - Valid load: every digit ≤9, sec tens ≤5, minutes ≤MAX_MIN. Value is captured, state becomes IDLE and expired clears.
  - Invalid load: load_err pulses for one cycle; value and state are unchanged.
- load in RUN: ignored, and load_err is not asserted.
- start:
  - IDLE/PAUSED with value ≠00:00: go to RUN.
  - Value 00:00: ignored.
  - DONE or RUN: ignored.
- pause: RUN goes to PAUSED; ignored in other states.
- Decrement (RUN and step):
  - sec ones 0 borrows from sec tens.
  - sec 00 borrows from minutes and becomes 59.
  - No wrap below 00:00.
- Expiry: a step that makes the value 00:00 moves to DONE. done pulses in the cycle after that step; expired rises together with done.
- Steps outside RUN are dropped, never accumulated.
- Simultaneous events:
  - start + step in IDLE/PAUSED: enter RUN; that step is dropped.
  - pause + step in RUN: go to PAUSED with no decrement.
  - clear + anything: clear wins.
- running = (state == RUN), registered.

Optional Feature:
- Macro: TICK_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - Last valid loaded value is held in a reload register.
  - On expiry the block reloads that value and stays in RUN.
  - done pulses on every expiry; expired is never set; DONE is unreachable.
- Undefined:
  - No reload register.
  - Expiry behaviour is as specified above.

Decomposition:
- Package tick_countdown_pkg:
  - state enum.
  - BCD_W = 4.
  - SEC_TENS_MAX = 5.
  - BCD digit-validity function.
- Sub-module tick_sync_edge:
  - Contains the SYNC_STAGES synchroniser and the toggle detector.
  - Outputs the step pulse.
  - Reused by other divider consumers.

Test Plan:
- Reset: hold rst_n low mid-count from 00:30 RUN → within the same cycle all outputs are 0 and state is IDLE; after release, tick_in toggles cause no change.
- Load 01:00, start, one tick_in toggle → sec_bcd=59, min_bcd=00 exactly SYNC_STAGES+1 clk edges after the toggle; 3 more toggles → 00:56.
- Load 00:02, start, two toggles:
  - done is high for exactly one cycle, expired=1, running=0.
  - Further toggles leave 00:00.
  - start is ignored until clear or load.
- Load 00:60 → load_err one-cycle pulse, value unchanged. Load 100:00 with MAX_MIN=99 (digit A) → load_err.
- In RUN at 00:10:
  - pause coincident with step → PAUSED at 00:10.
  - start coincident with step → RUN, still 00:10.
  - Next step → 00:09.
- Auto-reload build: load 00:02, start, four toggles → done pulses twice, final value 00:02, running stays 1.
